// File: rtl/axil_host_slice_if.sv
// AXI4-Lite bus bundle shared by the host-facing and user-IP-facing sides of axil_host_slice.
interface axil_host_slice_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_host_slice.sv
// AXI4-Lite register slice, one outstanding transaction per direction, with completion counters.
// Define AXIL_SLICE_TIMEOUT_EN to turn a silent downstream into SLVERR after TIMEOUT_CYC cycles.
module axil_host_slice #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  axil_host_slice_if.slave  s_axi,
  axil_host_slice_if.master m_axi,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
);
  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_t;

  wstate_t           r_wstate, w_wstate_n;
  logic              r_aw_held, w_aw_held_n;
  logic              r_w_held, w_w_held_n;
  logic              r_awready, w_awready_n;
  logic              r_wready, w_wready_n;
  logic              r_m_awvalid, w_m_awvalid_n;
  logic              r_m_wvalid, w_m_wvalid_n;
  logic              r_m_bready, w_m_bready_n;
  logic              r_bvalid, w_bvalid_n;
  logic [1:0]        r_bresp, w_bresp_n;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n;
  logic [STRB_W-1:0] r_wstrb, w_wstrb_n;
  logic [31:0]       r_wr_count, w_wr_count_n;

  rstate_t           r_rstate, w_rstate_n;
  logic              r_arready, w_arready_n;
  logic              r_m_arvalid, w_m_arvalid_n;
  logic              r_m_rready, w_m_rready_n;
  logic              r_rvalid, w_rvalid_n;
  logic [1:0]        r_rresp, w_rresp_n;
  logic [ADDR_W-1:0] r_araddr, w_araddr_n;
  logic [DATA_W-1:0] r_rdata, w_rdata_n;
  logic [31:0]       r_rd_count, w_rd_count_n;

`ifdef AXIL_SLICE_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_wtimer, w_wtimer_n;
  logic [TW-1:0] r_rtimer, w_rtimer_n;
`endif

  // Write direction: AW and W are collected independently before one downstream issue.
  always_comb begin
    w_wstate_n    = r_wstate;
    w_aw_held_n   = r_aw_held;
    w_w_held_n    = r_w_held;
    w_awready_n   = r_awready;
    w_wready_n    = r_wready;
    w_m_awvalid_n = r_m_awvalid;
    w_m_wvalid_n  = r_m_wvalid;
    w_m_bready_n  = r_m_bready;
    w_bvalid_n    = r_bvalid;
    w_bresp_n     = r_bresp;
    w_awaddr_n    = r_awaddr;
    w_wdata_n     = r_wdata;
    w_wstrb_n     = r_wstrb;
    w_wr_count_n  = r_wr_count;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi.awvalid && r_awready) begin
          w_aw_held_n = 1'b1;
          w_awaddr_n  = s_axi.awaddr;
        end
        if (s_axi.wvalid && r_wready) begin
          w_w_held_n = 1'b1;
          w_wdata_n  = s_axi.wdata;
          w_wstrb_n  = s_axi.wstrb;
        end
        w_awready_n = !w_aw_held_n;
        w_wready_n  = !w_w_held_n;
        if (w_aw_held_n && w_w_held_n) begin
          w_wstate_n    = W_ISSUE;
          w_aw_held_n   = 1'b0;
          w_w_held_n    = 1'b0;
          w_awready_n   = 1'b0;
          w_wready_n    = 1'b0;
          w_m_awvalid_n = 1'b1;
          w_m_wvalid_n  = 1'b1;
        end
      end
      W_ISSUE: begin
        if (r_m_awvalid && m_axi.awready) w_m_awvalid_n = 1'b0;
        if (r_m_wvalid && m_axi.wready)   w_m_wvalid_n  = 1'b0;
        if (!w_m_awvalid_n && !w_m_wvalid_n) begin
          w_wstate_n   = W_WAIT;
          w_m_bready_n = 1'b1;
        end
      end
      W_WAIT: begin
        if (m_axi.bvalid) begin
          w_wstate_n   = W_RESP;
          w_bresp_n    = m_axi.bresp;
          w_m_bready_n = 1'b0;
          w_bvalid_n   = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_wstate_n   = W_IDLE;
          w_bvalid_n   = 1'b0;
          w_wr_count_n = r_wr_count + 32'd1;
          w_awready_n  = 1'b1;
          w_wready_n   = 1'b1;
        end
      end
    endcase
`ifdef AXIL_SLICE_TIMEOUT_EN
    w_wtimer_n = '0;
    if ((r_wstate == W_ISSUE || r_wstate == W_WAIT) && w_wstate_n == r_wstate) begin
      if (r_wtimer == TO_LAST) begin
        w_wstate_n    = W_RESP;
        w_m_awvalid_n = 1'b0;
        w_m_wvalid_n  = 1'b0;
        w_m_bready_n  = 1'b0;
        w_bvalid_n    = 1'b1;
        w_bresp_n     = 2'b10;
      end else begin
        w_wtimer_n = r_wtimer + 1'b1;
      end
    end
`endif
  end

  // Read direction: rready is only raised in R_WAIT so the user IP sees it drop right after capture.
  always_comb begin
    w_rstate_n    = r_rstate;
    w_arready_n   = r_arready;
    w_m_arvalid_n = r_m_arvalid;
    w_m_rready_n  = r_m_rready;
    w_rvalid_n    = r_rvalid;
    w_rresp_n     = r_rresp;
    w_araddr_n    = r_araddr;
    w_rdata_n     = r_rdata;
    w_rd_count_n  = r_rd_count;
    case (r_rstate)
      R_IDLE: begin
        w_arready_n = 1'b1;
        if (s_axi.arvalid && r_arready) begin
          w_rstate_n    = R_ISSUE;
          w_araddr_n    = s_axi.araddr;
          w_arready_n   = 1'b0;
          w_m_arvalid_n = 1'b1;
        end
      end
      R_ISSUE: begin
        if (m_axi.arready) begin
          w_rstate_n    = R_WAIT;
          w_m_arvalid_n = 1'b0;
          w_m_rready_n  = 1'b1;
        end
      end
      R_WAIT: begin
        if (m_axi.rvalid) begin
          w_rstate_n   = R_RESP;
          w_rdata_n    = m_axi.rdata;
          w_rresp_n    = m_axi.rresp;
          w_m_rready_n = 1'b0;
          w_rvalid_n   = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi.rready) begin
          w_rstate_n   = R_IDLE;
          w_rvalid_n   = 1'b0;
          w_rd_count_n = r_rd_count + 32'd1;
          w_arready_n  = 1'b1;
        end
      end
    endcase
`ifdef AXIL_SLICE_TIMEOUT_EN
    w_rtimer_n = '0;
    if ((r_rstate == R_ISSUE || r_rstate == R_WAIT) && w_rstate_n == r_rstate) begin
      if (r_rtimer == TO_LAST) begin
        w_rstate_n    = R_RESP;
        w_m_arvalid_n = 1'b0;
        w_m_rready_n  = 1'b0;
        w_rvalid_n    = 1'b1;
        w_rresp_n     = 2'b10;
        w_rdata_n     = DATA_W'(32'h0BADC0DE);
      end else begin
        w_rtimer_n = r_rtimer + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate    <= W_IDLE;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_m_bready  <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wr_count  <= '0;
      r_rstate    <= R_IDLE;
      r_arready   <= 1'b0;
      r_m_arvalid <= 1'b0;
      r_m_rready  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rresp     <= '0;
      r_araddr    <= '0;
      r_rdata     <= '0;
      r_rd_count  <= '0;
`ifdef AXIL_SLICE_TIMEOUT_EN
      r_wtimer    <= '0;
      r_rtimer    <= '0;
`endif
    end else begin
      r_wstate    <= w_wstate_n;
      r_aw_held   <= w_aw_held_n;
      r_w_held    <= w_w_held_n;
      r_awready   <= w_awready_n;
      r_wready    <= w_wready_n;
      r_m_awvalid <= w_m_awvalid_n;
      r_m_wvalid  <= w_m_wvalid_n;
      r_m_bready  <= w_m_bready_n;
      r_bvalid    <= w_bvalid_n;
      r_bresp     <= w_bresp_n;
      r_awaddr    <= w_awaddr_n;
      r_wdata     <= w_wdata_n;
      r_wstrb     <= w_wstrb_n;
      r_wr_count  <= w_wr_count_n;
      r_rstate    <= w_rstate_n;
      r_arready   <= w_arready_n;
      r_m_arvalid <= w_m_arvalid_n;
      r_m_rready  <= w_m_rready_n;
      r_rvalid    <= w_rvalid_n;
      r_rresp     <= w_rresp_n;
      r_araddr    <= w_araddr_n;
      r_rdata     <= w_rdata_n;
      r_rd_count  <= w_rd_count_n;
`ifdef AXIL_SLICE_TIMEOUT_EN
      r_wtimer    <= w_wtimer_n;
      r_rtimer    <= w_rtimer_n;
`endif
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  assign m_axi.awvalid = r_m_awvalid;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.wvalid  = r_m_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.bready  = r_m_bready;
  assign m_axi.arvalid = r_m_arvalid;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.rready  = r_m_rready;

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
endmodule

// File: doc/axil_host_slice.md
# axil_host_slice

AXI4-Lite register slice between the shell's host-facing AXI4-Lite master and the metered user IP's control slave. It registers and re-issues every host transaction, allows one outstanding transaction per direction, counts completed reads and writes, and runs the downstream read handshake the user IP needs: rready is held only until the data beat is captured. An optional watchdog converts a silent downstream into an SLVERR response.

## Interface
- ADDR_W, 16, address width on both sides
- DATA_W, 32, data width; wstrb is DATA_W/8
- TIMEOUT_CYC, 255, cycles a downstream wait may last before the watchdog fires (used only with the macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_aw{valid,ready,addr}  in/out/in  1/1/ADDR_W  host write address
- s_axi_w{valid,ready,data,strb}  in/out/in/in  1/1/DATA_W/DATA_W/8  host write data
- s_axi_b{valid,ready,resp}  out/in/out  1/1/2  host write response
- s_axi_ar{valid,ready,addr}  in/out/in  1/1/ADDR_W  host read address
- s_axi_r{valid,ready,data,resp}  out/in/out/out  1/1/DATA_W/2  host read data
- m_axi_*  mirror of s_axi_* with directions reversed, toward the user IP
- wr_count  out  32  completed host writes, wraps at 2^32
- rd_count  out  32  completed host reads, wraps at 2^32

## Operation
- Reset values: all *valid and *ready outputs 0; addresses, data, strb, resp and counters 0; both FSMs in IDLE.
- Write FSM: W_IDLE → W_ISSUE → W_WAIT → W_RESP → W_IDLE.
  - W_IDLE: s_awready and s_wready are 1 while the matching channel is not yet latched. AW and W are latched independently, in either order or in the same cycle. Once both are held, go to W_ISSUE.
  - W_ISSUE: drive m_awvalid and m_wvalid. Each valid drops on its own handshake. Once both have completed, go to W_WAIT.
  - W_WAIT: m_bready=1. On m_bvalid, capture bresp and go to W_RESP.
  - W_RESP: s_bvalid=1 with the captured bresp. On s_bready, increment wr_count and return to W_IDLE.
- Read FSM: R_IDLE → R_ISSUE → R_WAIT → R_RESP → R_IDLE.
  - R_IDLE: s_arready=1. Latch araddr on handshake.
  - R_ISSUE: m_arvalid=1 until m_arready.
  - R_WAIT: m_rready=1. On m_rvalid, capture rdata/rresp. m_rready drops the next cycle and stays 0 outside R_WAIT, which lets the downstream return to idle.
  - R_RESP: s_rvalid=1. On s_rready, increment rd_count and return to R_IDLE.
- Read and write FSMs run independently and may be active concurrently.
- Payload passes through unmodified: addresses, data, strb, resp.
- m_bready is 0 outside W_WAIT. Any downstream bvalid seen outside W_WAIT is ignored.

## Timing
- Ready outputs are registered. They go to 1 on the first clk edge after rst_n deasserts.
- Write latency with AW+W accepted at cycle 0:
  - m_awvalid/m_wvalid at cycle 1.
  - With immediate downstream ready and bvalid, s_bvalid at cycle 3 at the earliest.
- Read latency with AR accepted at cycle 0:
  - m_arvalid at cycle 1.
  - With immediate downstream, s_rvalid at cycle 3 at the earliest.
- s_*valid and its payload stay stable until the handshake, per AXI.
- A counter increments in the same cycle as its s_bvalid/s_rvalid handshake.
- rst_n asserted mid-transaction: both FSMs abort to IDLE at once, all outputs return to reset values, and the transaction is not counted.

## Configuration
- AXIL_SLICE_TIMEOUT_EN defined:
  - A per-direction cycle counter runs in W_ISSUE/W_WAIT and in R_ISSUE/R_WAIT, and clears on every state change.
  - When it reaches TIMEOUT_CYC: drop the m_* valids and readies, go to *_RESP with resp=2'b10 (SLVERR); reads also return rdata=32'h0BADC0DE.
  - Timed-out transactions are still counted.
- AXIL_SLICE_TIMEOUT_EN undefined: no counter; the FSMs wait indefinitely.

## Test plan
- Write 0x04 ← 0x12345678, AW and W in the same cycle, downstream always ready with bvalid=1 → m_awaddr=0x04, m_wdata=0x12345678, s_bresp=0, wr_count=1.
- W presented 3 cycles before AW → a single downstream write with correct address and data; s_bvalid after both are accepted.
- Read 0x0C while downstream rdata=0xCAFEF00D → s_rdata=0xCAFEF00D, m_rready high for exactly one cycle after the capture, rd_count=1.
- Host holds s_rready=0 for 10 cycles → s_rvalid and s_rdata stay stable, and no new m_arvalid is issued until the handshake.
- With the macro and TIMEOUT_CYC=8, downstream never asserts rvalid → s_rresp=2'b10, s_rdata=0x0BADC0DE 8 cycles after entering the wait, rd_count increments.
- rst_n pulsed low while in R_WAIT and W_ISSUE → all valids 0, counters unchanged from reset (0), and the next read completes normally.
